// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: drains the FIFO in bursts (full level, flush, or FIFO_BURST_DRAIN_TIMEOUT_EN timeout) onto a valid/ready stream.
// Latency: start -> read strobe +1 -> m_valid_o +2; reads stall while m_valid_o && !m_ready_i.
module fifo_burst_drain #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int BURST   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [$clog2(DEPTH):0] fifo_filled_i,
    input  logic                   fifo_empty_i,
    output logic                   fifo_rd_o,
    input  logic [WIDTH-1:0]       fifo_data_i,
    input  logic                   flush_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [WIDTH-1:0]       m_data_o,
    output logic                   m_last_o,
    output logic                   busy_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] BURST_LEN = CW'(BURST);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BURST     = 2'd1,
        ST_WAIT_LAST = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_remaining;
    logic [CW-1:0] w_remaining_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic          w_start;
    logic          w_start_to;
    logic          w_rd;
    logic          w_accept;

    generate
        if (BURST < 1 || BURST > DEPTH) begin : g_bad_burst
            $error("fifo_burst_drain: BURST must lie within 1..DEPTH");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("fifo_burst_drain: TIMEOUT must be at least 1");
        end
    endgenerate

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_timer;

    assign w_start_to = (r_timer == TIMER_MAX) && !fifo_empty_i;

    // Counts idle cycles with data waiting; saturates so the timeout stays armed.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_timer <= '0;
        end else if (r_state != ST_IDLE || fifo_empty_i || w_start) begin
            r_timer <= '0;
        end else if (r_timer != TIMER_MAX) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_start_to = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_valid_nxt     = r_valid;
        w_last_nxt      = r_last;
        w_start         = 1'b0;
        w_rd            = 1'b0;
        w_accept        = r_valid && m_ready_i;

        case (r_state)
            ST_IDLE: begin
                if (fifo_filled_i >= BURST_LEN) begin
                    w_start         = 1'b1;
                    w_remaining_nxt = BURST_LEN;
                end else if (flush_i && !fifo_empty_i) begin
                    w_start         = 1'b1;
                    w_remaining_nxt = fifo_filled_i;
                end else if (w_start_to) begin
                    w_start         = 1'b1;
                    w_remaining_nxt = fifo_filled_i;
                end
                if (w_start) begin
                    w_state_nxt = ST_BURST;
                end
            end

            ST_BURST: begin
                // Empty with words still owed means the FIFO was reset underneath us.
                if (r_remaining != '0 && fifo_empty_i) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = '0;
                    w_valid_nxt     = 1'b0;
                    w_last_nxt      = 1'b0;
                end else if (r_remaining == '0) begin
                    w_state_nxt = r_valid ? ST_WAIT_LAST : ST_IDLE;
                end else begin
                    w_rd = !r_valid || m_ready_i;
                    if (w_rd) begin
                        w_remaining_nxt = r_remaining - 1'b1;
                        w_valid_nxt     = 1'b1;
                        w_last_nxt      = (r_remaining == CW'(1));
                        if (r_remaining == CW'(1)) begin
                            w_state_nxt = ST_WAIT_LAST;
                        end
                    end else if (w_accept) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end

            ST_WAIT_LAST: begin
                if (w_accept && r_last) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = '0;
                w_valid_nxt     = 1'b0;
                w_last_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign fifo_rd_o = w_rd;
    assign m_valid_o = r_valid;
    assign m_last_o  = r_last;
    assign m_data_o  = fifo_data_i;
    assign busy_o    = (r_state != ST_IDLE);

endmodule
